// File: rtl/mul_seq_pkg.sv
// Shared types and helpers for the Nios II multicycle multiply sequencer.
package mul_seq_pkg;

    // Nios II multiply flavours; high-word ops return product bits 63:32.
    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULXUU = 2'd1,
        MULXSU = 2'd2,
        MULXSS = 2'd3
    } mul_op_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPass1 = 2'd1,
        StPass2 = 2'd2,
        StPass3 = 2'd3
    } mul_seq_state_t;

    localparam int unsigned SumWidth   = 49;
    localparam int unsigned CarryWidth = 17;

    // Low 49 bits of the partial-product sum: p1 + (p2 << 16) + (p3 << 16).
    function automatic logic [SumWidth-1:0] sum_partials(
        input logic [31:0] p1,
        input logic [31:0] p2,
        input logic [31:0] p3
    );
        return {17'b0, p1} + {1'b0, p2, 16'b0} + {1'b0, p3, 16'b0};
    endfunction

endpackage

// File: rtl/nios2_mul_hi_correct.sv
// Converts the unsigned high product word into the signed-variant high word.
module nios2_mul_hi_correct
    import mul_seq_pkg::*;
(
    input  logic [31:0] hu,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  mul_op_t     op,
    output logic [31:0] hi
);

    // Two's-complement fix-up: a negative signed operand adds -2^32*other to the product.
    always_comb begin
        hi = hu;
        if ((op == MULXSU || op == MULXSS) && a[31]) begin
            hi = hi - b;
        end
        if (op == MULXSS && b[31]) begin
            hi = hi - a;
        end
    end

endmodule

// File: rtl/nios2_mul_sequencer.sv
// Drives an external 16x16 three-partial-product multiply cell and assembles
// MUL / MULXUU / MULXSU / MULXSS results with a single-cycle done pulse.
module nios2_mul_sequencer
    import mul_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] cell_src1,
    output logic [31:0] cell_src2,
    output logic        cell_en,
    input  logic [31:0] cell_p1,
    input  logic [31:0] cell_p2,
    input  logic [31:0] cell_p3
);

    mul_seq_state_t        state_q, state_d;
    logic [31:0]           a_q, a_d;
    logic [31:0]           b_q, b_d;
    mul_op_t               op_q, op_d;
    logic [CarryWidth-1:0] carry_q, carry_d;
    logic [31:0]           result_q, result_d;
    logic                  done_q, done_d;

    logic [SumWidth-1:0]   sum;
    logic [31:0]           hu;
    logic [31:0]           hi;

    assign sum = sum_partials(cell_p1, cell_p2, cell_p3);
    // In PASS3 cell_p1 holds a[31:16]*b[31:16]; the low-half carry completes the unsigned high word.
    assign hu  = cell_p1 + {15'b0, carry_q};

    nios2_mul_hi_correct u_hi_correct (
        .hu (hu),
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .hi (hi)
    );

    assign busy   = (state_q != StIdle);
    assign done   = done_q;
    assign result = result_q;

    // Next-state, latch updates and cell drive for the pass sequence.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        carry_d   = carry_q;
        result_d  = result_q;
        done_d    = 1'b0;
        cell_src1 = 32'h0;
        cell_src2 = 32'h0;
        cell_en   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = src1;
                    b_d     = src2;
                    op_d    = mul_op_t'(op);
                    state_d = StPass1;
                end
            end
            StPass1: begin
                cell_src1 = a_q;
                cell_src2 = b_q;
                cell_en   = 1'b1;
                state_d   = StPass2;
            end
            StPass2: begin
                carry_d = sum[48:32];
                if (op_q == MUL) begin
                    result_d = sum[31:0];
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end else begin
                    // Reuse the p1 multiplier for the high halves.
                    cell_src1 = {16'h0, a_q[31:16]};
                    cell_src2 = {16'h0, b_q[31:16]};
                    cell_en   = 1'b1;
                    state_d   = StPass3;
                end
            end
            StPass3: begin
                result_d = hi;
                done_d   = 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            op_q     <= MUL;
            carry_q  <= '0;
            result_q <= 32'h0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_nios2_mul_sequencer.sv
// Directed bench for nios2_mul_sequencer with a behavioural multiply cell.
module tb_nios2_mul_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] src1 = 32'h0;
    logic [31:0] src2 = 32'h0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] cell_src1;
    logic [31:0] cell_src2;
    logic        cell_en;
    logic [31:0] cell_p1;
    logic [31:0] cell_p2;
    logic [31:0] cell_p3;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    nios2_mul_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .cell_src1 (cell_src1),
        .cell_src2 (cell_src2),
        .cell_en   (cell_en),
        .cell_p1   (cell_p1),
        .cell_p2   (cell_p2),
        .cell_p3   (cell_p3)
    );

    // Behavioural cell: enabled registers, asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cell_p1 <= 32'h0;
            cell_p2 <= 32'h0;
            cell_p3 <= 32'h0;
        end else if (cell_en) begin
            cell_p1 <= {16'h0, cell_src1[15:0]} * {16'h0, cell_src2[15:0]};
            cell_p2 <= {16'h0, cell_src1[15:0]} * {16'h0, cell_src2[31:16]};
            cell_p3 <= {16'h0, cell_src1[31:16]} * {16'h0, cell_src2[15:0]};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one op at a negedge and follow it to done; leaves the bench in the done cycle.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp, input int lat);
        int n;
        start = 1'b1;
        op    = o;
        src1  = x;
        src2  = y;
        step();
        start = 1'b0;
        n = 1;
        check({tag, ".busy1"}, {31'b0, busy}, 32'd1);
        check({tag, ".p1_src1"}, cell_src1, x);
        check({tag, ".p1_src2"}, cell_src2, y);
        check({tag, ".p1_en"}, {31'b0, cell_en}, 32'd1);
        step();
        n = 2;
        check({tag, ".p2_en"}, {31'b0, cell_en}, {31'b0, (o != 2'd0)});
        if (o != 2'd0) begin
            check({tag, ".p2_src1"}, cell_src1, {16'h0, x[31:16]});
            check({tag, ".p2_src2"}, cell_src2, {16'h0, y[31:16]});
        end
        while (!done && n < 10) begin
            step();
            n++;
        end
        check({tag, ".latency"}, n, lat);
        check({tag, ".result"}, result, exp);
        check({tag, ".busy_done"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int dones;
        int first_done;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst.busy", {31'b0, busy}, 32'd0);
        check("rst.done", {31'b0, done}, 32'd0);
        check("rst.result", result, 32'h0);
        check("rst.cell_en", {31'b0, cell_en}, 32'd0);
        check("rst.cell_src1", cell_src1, 32'h0);
        check("rst.cell_src2", cell_src2, 32'h0);
        reset_n = 1'b1;
        step();

        // Basic ops, back-to-back (each starts in the previous done cycle)
        run_op("mul_small",   2'd0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 3);
        run_op("mulxuu_small", 2'd1, 32'h0001_0003, 32'h0002_0005, 32'h0000_0002, 4);
        run_op("mulxuu_ones", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4);
        run_op("mul_ones",    2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 3);
        run_op("mulxss_ones", 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4);
        run_op("mulxss_min",  2'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 4);
        run_op("mulxsu_ones", 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4);
        run_op("mulxsu_min2", 2'd2, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 4);
        run_op("mulxsu_pos",  2'd2, 32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0002, 4);
        run_op("mulxss_neg",  2'd3, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 4);
        step();

        // Start pulsed while busy is ignored; exactly one done
        start = 1'b1;
        op    = 2'd1;
        src1  = 32'h0001_0003;
        src2  = 32'h0002_0005;
        step();
        op    = 2'd0;
        src1  = 32'h1234_5678;
        src2  = 32'h9ABC_DEF0;
        step();
        start = 1'b0;
        dones = 0;
        first_done = 0;
        for (int c = 2; c <= 9; c++) begin
            if (done) begin
                dones++;
                if (first_done == 0) first_done = c;
                check("busy_start.result", result, 32'h0000_0002);
            end
            step();
        end
        check("busy_start.dones", dones, 32'd1);
        check("busy_start.when", first_done, 32'd4);

        // Asynchronous reset at T+2 aborts the op
        start = 1'b1;
        op    = 2'd1;
        src1  = 32'hFFFF_FFFF;
        src2  = 32'hFFFF_FFFF;
        step();
        start = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        check("abort.busy", {31'b0, busy}, 32'd0);
        check("abort.done", {31'b0, done}, 32'd0);
        check("abort.result", result, 32'h0);
        check("abort.cell_en", {31'b0, cell_en}, 32'd0);
        check("abort.cell_src1", cell_src1, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (done) dones++;
        end
        check("abort.no_done", dones, 32'd0);
        check("abort.idle", {31'b0, busy}, 32'd0);
        run_op("after_abort", 2'd1, 32'h0001_0003, 32'h0002_0005, 32'h0000_0002, 4);
        run_op("after_abort_mul", 2'd0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 3);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
